// File: rtl/xheep_exit_status_monitor.sv
// rtl/xheep_exit_status_monitor.sv - exit handshake monitor: PASS/FAIL/TIMEOUT flags and status LED
module xheep_exit_status_monitor #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned SLOW_DIV_LOG2  = 24,
  parameter int unsigned FAST_DIV_LOG2  = 21,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk_gen,
  input  logic        rst_n,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  input  logic        clear_i,
  output logic        status_led_o,
  output logic        pass_o,
  output logic        fail_o,
  output logic        timeout_o,
  output logic [31:0] exit_code_o
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_e;

  localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

  state_e                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q, sync_d;
  logic                     valid_prev_q, valid_prev_d;
  logic                     pass_q, pass_d;
  logic                     fail_q, fail_d;
  logic                     timeout_q, timeout_d;
  logic [31:0]              code_q, code_d;
  logic [31:0]              wd_q, wd_d;
  logic [SLOW_DIV_LOG2-1:0] blink_q, blink_d;
  logic                     led_q, led_d;
  logic                     rise;

  // Edge detector history is deliberately untouched by clear_i so a held exit_valid_i cannot retrigger.
  assign rise = sync_q[SYNC_STAGES-1] & ~valid_prev_q;

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], exit_valid_i};
    valid_prev_d = sync_q[SYNC_STAGES-1];
    state_d      = state_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    timeout_d    = timeout_q;
    code_d       = code_q;
    wd_d         = wd_q;
    blink_d      = blink_q + SLOW_DIV_LOG2'(1);

    case (state_q)
      ST_RUN: begin
        if (wd_q != '1) wd_d = wd_q + 32'd1;
        if (rise) begin
          code_d = exit_value_i;
          if (exit_value_i == 32'd0) begin
            state_d = ST_PASS;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
          end
        end else if (WD_EN && wd_q == WD_LAST) begin
          state_d   = ST_TIMEOUT;
          timeout_d = 1'b1;
        end
      end
      ST_TIMEOUT: begin
        if (rise) begin
          code_d = exit_value_i;
          if (exit_value_i == 32'd0) begin
            state_d = ST_PASS;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (clear_i) begin
      state_d   = ST_RUN;
      pass_d    = 1'b0;
      fail_d    = 1'b0;
      timeout_d = 1'b0;
      code_d    = 32'd0;
      wd_d      = 32'd0;
    end

    // Restarting the blink phase on every transition makes the first phase of each pattern LED-off.
    if (clear_i || state_d != state_q) blink_d = '0;

    case (state_q)
      ST_RUN:     led_d = blink_q[SLOW_DIV_LOG2-1];
      ST_PASS:    led_d = 1'b1;
      ST_FAIL:    led_d = blink_q[FAST_DIV_LOG2-1];
      ST_TIMEOUT: led_d = blink_q[FAST_DIV_LOG2-1] & blink_q[SLOW_DIV_LOG2-1];
      default:    led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      sync_q       <= '0;
      valid_prev_q <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
      code_q       <= 32'd0;
      wd_q         <= 32'd0;
      blink_q      <= '0;
      led_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      valid_prev_q <= valid_prev_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      timeout_q    <= timeout_d;
      code_q       <= code_d;
      wd_q         <= wd_d;
      blink_q      <= blink_d;
      led_q        <= led_d;
    end
  end

  assign status_led_o = led_q;
  assign pass_o       = pass_q;
  assign fail_o       = fail_q;
  assign timeout_o    = timeout_q;
  assign exit_code_o  = code_q;

endmodule

// File: tb/tb_xheep_exit_status_monitor.sv
// tb/tb_xheep_exit_status_monitor.sv - directed bench for xheep_exit_status_monitor
module tb_xheep_exit_status_monitor;

  logic        clk_gen = 1'b0;
  logic        rst_n;
  logic        exit_valid_i;
  logic [31:0] exit_value_i;
  logic        clear_i;
  logic        status_led_o;
  logic        pass_o;
  logic        fail_o;
  logic        timeout_o;
  logic [31:0] exit_code_o;

  int vectors = 0;
  int miscompares = 0;

  logic [0:5]  fail_pat = 6'b001100;
  logic [0:15] tmo_pat  = 16'b0000000000110011;

  xheep_exit_status_monitor #(
    .SYNC_STAGES   (2),
    .SLOW_DIV_LOG2 (4),
    .FAST_DIV_LOG2 (2),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_gen     (clk_gen),
    .rst_n       (rst_n),
    .exit_valid_i(exit_valid_i),
    .exit_value_i(exit_value_i),
    .clear_i     (clear_i),
    .status_led_o(status_led_o),
    .pass_o      (pass_o),
    .fail_o      (fail_o),
    .timeout_o   (timeout_o),
    .exit_code_o (exit_code_o)
  );

  always #5 clk_gen = ~clk_gen;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_gen);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    exit_valid_i = 1'b0;
    exit_value_i = 32'd0;
    clear_i      = 1'b0;
    #12;
    chk("rst_led", status_led_o, 0);
    chk("rst_pass", pass_o, 0);
    chk("rst_fail", fail_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_code", exit_code_o, 0);
    @(negedge clk_gen);
    rst_n = 1'b1;

    // Pass run: valid first sampled at edge 10
    tick(8);
    chk("run_led_e8", status_led_o, 0);
    tick(1);
    chk("run_led_e9", status_led_o, 1);
    exit_valid_i = 1'b1;
    tick(2);
    chk("pass_e11_early", pass_o, 0);
    tick(1);
    chk("pass_e12", pass_o, 1);
    chk("pass_code", exit_code_o, 0);
    chk("pass_nofail", fail_o, 0);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("pass_led", status_led_o, 1);
    end

    // Fail run with LED fast pattern
    exit_valid_i = 1'b0;
    clear_i      = 1'b1;
    tick(1);
    clear_i = 1'b0;
    chk("clr_pass", pass_o, 0);
    tick(3);
    exit_value_i = 32'hDEAD_0001;
    exit_valid_i = 1'b1;
    tick(2);
    chk("fail_early", fail_o, 0);
    tick(1);
    chk("fail_flag", fail_o, 1);
    chk("fail_code", exit_code_o, 32'hDEAD_0001);
    chk("fail_nopass", pass_o, 0);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("fail_led", status_led_o, fail_pat[i]);
    end

    // Terminal: a later rise with code 0 is ignored
    exit_valid_i = 1'b0;
    tick(3);
    exit_value_i = 32'd0;
    exit_valid_i = 1'b1;
    tick(4);
    chk("term_fail", fail_o, 1);
    chk("term_pass", pass_o, 0);
    chk("term_code", exit_code_o, 32'hDEAD_0001);

    // Clear with valid held high: no retrigger until a new rise
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    chk("hclr_fail", fail_o, 0);
    chk("hclr_pass", pass_o, 0);
    chk("hclr_timeout", timeout_o, 0);
    chk("hclr_code", exit_code_o, 0);
    tick(5);
    chk("hclr_noretrig_pass", pass_o, 0);
    chk("hclr_noretrig_fail", fail_o, 0);
    exit_valid_i = 1'b0;
    tick(3);
    exit_valid_i = 1'b1;
    tick(3);
    chk("rearm_pass", pass_o, 1);

    // Clear coincident with a rise drops the rise
    exit_valid_i = 1'b0;
    clear_i      = 1'b1;
    tick(1);
    clear_i = 1'b0;
    tick(3);
    exit_value_i = 32'd5;
    exit_valid_i = 1'b1;
    tick(2);
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    chk("coinc_fail", fail_o, 0);
    chk("coinc_pass", pass_o, 0);
    tick(4);
    chk("coinc_fail_later", fail_o, 0);
    chk("coinc_code", exit_code_o, 0);

    // Rise reaches the detector on the watchdog expiry edge
    exit_valid_i = 1'b0;
    clear_i      = 1'b1;
    tick(1);
    clear_i = 1'b0;
    tick(97);
    exit_value_i = 32'h0000_0007;
    exit_valid_i = 1'b1;
    tick(2);
    chk("race_e99_fail", fail_o, 0);
    chk("race_e99_tmo", timeout_o, 0);
    tick(1);
    chk("race_fail", fail_o, 1);
    chk("race_tmo", timeout_o, 0);
    chk("race_code", exit_code_o, 32'h0000_0007);

    // Async reset mid-blink in FAIL
    tick(3);
    chk("prerst_led", status_led_o, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_led", status_led_o, 0);
    chk("arst_fail", fail_o, 0);
    chk("arst_code", exit_code_o, 0);
    exit_valid_i = 1'b0;
    exit_value_i = 32'd0;
    #2;
    rst_n = 1'b1;

    // Watchdog expiry at edge 100 after release
    tick(99);
    chk("tmo_e99", timeout_o, 0);
    tick(1);
    chk("tmo_e100", timeout_o, 1);
    chk("tmo_pass", pass_o, 0);
    chk("tmo_fail", fail_o, 0);
    for (int i = 0; i < 16; i++) begin
      tick(1);
      chk("tmo_led", status_led_o, tmo_pat[i]);
    end

    // Late exit after timeout
    exit_valid_i = 1'b1;
    tick(3);
    chk("late_pass", pass_o, 1);
    chk("late_tmo", timeout_o, 1);
    chk("late_code", exit_code_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
